// File: rtl/hello_pkg.sv
// Shared letter codes and FSM states for the hello scroll encoder.
package hello_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_H     = 3'b000;
  localparam logic [CODE_W-1:0] CODE_E     = 3'b001;
  localparam logic [CODE_W-1:0] CODE_L     = 3'b010;
  localparam logic [CODE_W-1:0] CODE_O     = 3'b011;
  localparam logic [CODE_W-1:0] CODE_BLANK = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } state_e;

endpackage

// File: rtl/hello_char_encoder.sv
// ASCII to 3-bit letter code, case-insensitive for H/E/L/O.
module hello_char_encoder
  import hello_pkg::*;
(
  input  logic [7:0]        char_i,
  output logic [CODE_W-1:0] code_o
);

  // Setting bit 5 folds upper case onto lower case for letters.
  logic [7:0] low;
  assign low = char_i | 8'h20;

  always_comb begin
    code_o = CODE_BLANK;
    unique case (1'b1)
      (low == 8'h68): code_o = CODE_H;
      (low == 8'h65): code_o = CODE_E;
      (low == 8'h6c): code_o = CODE_L;
      (low == 8'h6f): code_o = CODE_O;
      default:        code_o = CODE_BLANK;
    endcase
  end

endmodule

// File: rtl/hello_scroll_encoder.sv
// Buffers an encoded message and drives a scrolling window
// of letter codes to the per-digit decoders.
module hello_scroll_encoder
  import hello_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         char_valid,
  input  logic [7:0]                   char_data,
  output logic                         char_ready,
  input  logic                         msg_commit,
  input  logic                         msg_clear,
  input  logic                         scroll_en,
  output logic                         busy,
  output logic [CODE_W*NUM_DIGITS-1:0] digit_codes
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);
  localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int TMR_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(MSG_LEN + NUM_DIGITS) + 1;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] buf_q [MSG_LEN];
  logic [CODE_W-1:0] buf_d [MSG_LEN];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [CODE_W-1:0] enc;
  logic              accept;
  logic              scroll;
  logic              tick;

  hello_char_encoder u_enc (
    .char_i (char_data),
    .code_o (enc)
  );

  assign accept = char_valid & char_ready;
  assign scroll = (32'(count_q) > NUM_DIGITS);
  assign tick   = (timer_q == TMR_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      for (int i = 0; i < MSG_LEN; i++)
        buf_q[i] <= CODE_BLANK;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    buf_d   = buf_q;
    if (msg_clear) begin
      state_d = IDLE;
      count_d = '0;
      ptr_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            buf_d[0] = enc;
            count_d  = CNT_W'(1);
            ptr_d    = '0;
            timer_d  = '0;
            state_d  = msg_commit ? SHOW : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            buf_d[count_q[PTR_W-1:0]] = enc;
            count_d = count_q + CNT_W'(1);
          end
          if (msg_commit) begin
            state_d = SHOW;
            ptr_d   = '0;
            timer_d = '0;
          end
        end
        SHOW: begin
          if (scroll_en && scroll) begin
            if (tick) begin
              timer_d = '0;
              if (32'(ptr_q) + 1 == 32'(count_q))
                ptr_d = '0;
              else
                ptr_d = ptr_q + PTR_W'(1);
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    char_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE:    char_ready = 1'b1;
      LOAD:    char_ready = (count_q < CNT_W'(MSG_LEN));
      SHOW:    busy = 1'b1;
      default: char_ready = 1'b0;
    endcase
  end

  // ptr stays 0 unless scrolling, so one wrap rule covers both views.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [IDX_W-1:0]  sum;
    logic [IDX_W-1:0]  cnt;
    logic [CODE_W-1:0] code;

    always_comb begin
      cnt  = IDX_W'(count_q);
      sum  = IDX_W'(ptr_q) + IDX_W'(g);
      code = CODE_BLANK;
      if (state_q != IDLE && IDX_W'(g) < cnt)
        code = buf_q[PTR_W'((sum >= cnt) ? sum - cnt : sum)];
    end

    assign digit_codes[CODE_W*g +: CODE_W] = code;
  end

endmodule
